// File: rtl/timer_gpio_nch_if.sv
// ---------------------------------------------------------------------------
// timer_gpio_nch_if
//   Synchronous configuration bus for the N-channel timer/GPIO block.
//
//   Signals:
//     wr_en  - one-cycle register write strobe
//     rd_en  - one-cycle register read strobe
//     addr   - {channel, reg[2:0]}
//     wdata  - write data
//     rdata  - read data, registered, valid the cycle after rd_en
//
//   Modports:
//     master - bus driver (CPU side / testbench)
//     slave  - peripheral side
// ---------------------------------------------------------------------------
interface timer_gpio_nch_if #(
    parameter int AW = 5,
    parameter int CW = 16
);
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    logic [CW-1:0] rdata;

    modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
    modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_gpio_nch.sv
// ---------------------------------------------------------------------------
// timer_gpio_nch
//   Parametrised N-channel timer/GPIO peripheral. Each channel has a period,
//   a compare value and a mode (off, one-shot, toggle, PWM) and drives one
//   registered output pin. A shared prescaler produces the count tick.
//
//   Ports:
//     clk     - system clock, rising edge
//     reset   - asynchronous, active-high reset
//     bus     - register bus (timer_gpio_nch_if.slave)
//     pin_in  - capture inputs, NCH bits (only with TIMER_GPIO_CAPTURE_EN)
//     pin     - channel output pins, registered
//     irq     - OR over channels of (status & irq_en)
//
//   Register map per channel (addr[2:0]):
//     0 CTRL    [1:0] mode, [2] enable, [3] irq_en; a write restarts the channel
//     1 PERIOD
//     2 COMPARE
//     3 COUNT   (read-only)
//     4 STATUS  [0] wrap, [1] capture; write-1-to-clear
//     5 CAPTURE (read-only)
//     6,7       read 0, writes ignored
//
//   Optional feature macro: TIMER_GPIO_CAPTURE_EN
//     Defined   : adds pin_in with 2-flop synchronisers and input capture.
//     Undefined : no pin_in port, CAPTURE reads 0, STATUS.capture stays 0.
// ---------------------------------------------------------------------------
module timer_gpio_nch #(
    parameter int NCH   = 4,
    parameter int CW    = 16,
    parameter int PRESC = 10,
    parameter int AW    = $clog2(NCH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    timer_gpio_nch_if.slave   bus,
`ifdef TIMER_GPIO_CAPTURE_EN
    input  logic [NCH-1:0]    pin_in,
`endif
    output logic [NCH-1:0]    pin,
    output logic              irq
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_TOGGLE  = 2'd2,
        MODE_PWM     = 2'd3
    } mode_e;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PERIOD  = 3'd1;
    localparam logic [2:0] REG_COMPARE = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_CAPTURE = 3'd5;

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [CHW-1:0] sel_ch;
    logic [2:0]     sel_reg;
    logic           sel_ok;

    always_comb begin
        sel_reg = bus.addr[2:0];
        // Shifting rather than slicing keeps NCH=1 (no channel bits) legal.
        sel_ch  = CHW'(bus.addr >> 3);
        sel_ok  = (int'(sel_ch) < NCH);
    end

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(PRESC - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture input synchronisers (optional)
    // ------------------------------------------------------------------
`ifdef TIMER_GPIO_CAPTURE_EN
    logic [NCH-1:0] sync1_q, sync2_q, hist_q;
    logic [NCH-1:0] cap_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Edge detect on the synchronised value; hist_q is only the previous sample.
    assign cap_rise = sync2_q & ~hist_q;
`endif

    // ------------------------------------------------------------------
    // Per-channel state, exported as arrays for the read mux and irq
    // ------------------------------------------------------------------
    logic [NCH-1:0] pin_v, irq_en_v, st_wrap_v, st_cap_v;
    logic [3:0]     ctrl_a    [NCH];
    logic [CW-1:0]  period_a  [NCH];
    logic [CW-1:0]  compare_a [NCH];
    logic [CW-1:0]  count_a   [NCH];
    logic [CW-1:0]  capture_a [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mode_e         mode_r;
        logic          en_r, irq_en_r, pin_r, st_wrap_r, st_cap_r;
        logic [CW-1:0] period_r, compare_r, count_r, capture_r;
        logic          hit, ctrl_wr, period_wr, compare_wr, status_wr;
        logic          active, wrap_evt;

        always_comb begin
            hit        = bus.wr_en && sel_ok && (int'(sel_ch) == g);
            ctrl_wr    = hit && (sel_reg == REG_CTRL);
            period_wr  = hit && (sel_reg == REG_PERIOD);
            compare_wr = hit && (sel_reg == REG_COMPARE);
            status_wr  = hit && (sel_reg == REG_STATUS);
            active     = en_r && (mode_r != MODE_OFF) && (period_r != '0);
            // >= so that lowering PERIOD below the count forces a wrap.
            // A CTRL write in the same cycle restarts the channel instead.
            wrap_evt   = tick && active && (count_r >= period_r) && !ctrl_wr;
        end

        // NOTE: asynchronous active-high reset clears every flop here,
        // including the configuration registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mode_r    <= MODE_OFF;
                en_r      <= 1'b0;
                irq_en_r  <= 1'b0;
                period_r  <= '0;
                compare_r <= '0;
                count_r   <= '0;
                pin_r     <= 1'b0;
                st_wrap_r <= 1'b0;
            end else begin
                if (ctrl_wr) begin
                    mode_r   <= mode_e'(bus.wdata[1:0]);
                    en_r     <= bus.wdata[2];
                    irq_en_r <= bus.wdata[3];
                    count_r  <= '0;
                    pin_r    <= 1'b0;
                end else if (period_r == '0) begin
                    count_r <= '0;
                    pin_r   <= 1'b0;
                end else if (!en_r || (mode_r == MODE_OFF)) begin
                    pin_r <= 1'b0;
                end else if (tick) begin
                    count_r <= wrap_evt ? '0 : count_r + 1'b1;
                    // Pin reflects the count seen in this tick (pre-advance).
                    unique case (mode_r)
                        MODE_ONESHOT: begin
                            pin_r <= !wrap_evt;
                            if (wrap_evt) en_r <= 1'b0;
                        end
                        MODE_TOGGLE:  if (wrap_evt) pin_r <= ~pin_r;
                        MODE_PWM:     pin_r <= (count_r < compare_r);
                        default:      pin_r <= 1'b0;
                    endcase
                end

                if (period_wr)  period_r  <= bus.wdata;
                if (compare_wr) compare_r <= bus.wdata;

                // Set beats a simultaneous write-1-to-clear.
                st_wrap_r <= wrap_evt | (st_wrap_r & ~(status_wr & bus.wdata[0]));
            end
        end

`ifdef TIMER_GPIO_CAPTURE_EN
        logic cap_evt;
        assign cap_evt = cap_rise[g] && en_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                capture_r <= '0;
                st_cap_r  <= 1'b0;
            end else begin
                // count_r is the pre-wrap value if a wrap lands in this cycle.
                if (cap_evt) capture_r <= count_r;
                st_cap_r <= cap_evt | (st_cap_r & ~(status_wr & bus.wdata[1]));
            end
        end
`else
        assign capture_r = '0;
        assign st_cap_r  = 1'b0;
`endif

        assign pin_v[g]     = pin_r;
        assign irq_en_v[g]  = irq_en_r;
        assign st_wrap_v[g] = st_wrap_r;
        assign st_cap_v[g]  = st_cap_r;
        assign ctrl_a[g]    = {irq_en_r, en_r, mode_r};
        assign period_a[g]  = period_r;
        assign compare_a[g] = compare_r;
        assign count_a[g]   = count_r;
        assign capture_a[g] = capture_r;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [CW-1:0] rd_val;

    always_comb begin
        // NOTE: default assigned first so no path leaves rd_val unassigned
        // (which would infer a latch).
        rd_val = '0;
        if (sel_ok) begin
            case (sel_reg)
                REG_CTRL:    rd_val = CW'(ctrl_a[sel_ch]);
                REG_PERIOD:  rd_val = period_a[sel_ch];
                REG_COMPARE: rd_val = compare_a[sel_ch];
                REG_COUNT:   rd_val = count_a[sel_ch];
                REG_STATUS:  rd_val = CW'({st_cap_v[sel_ch], st_wrap_v[sel_ch]});
                REG_CAPTURE: rd_val = capture_a[sel_ch];
                default:     rd_val = '0;
            endcase
        end
    end

    // rdata holds its value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata <= '0;
        end else if (bus.rd_en) begin
            bus.rdata <= rd_val;
        end
    end

    assign pin = pin_v;
    assign irq = |((st_wrap_v | st_cap_v) & irq_en_v);

endmodule

// File: tb/tb_timer_gpio_nch.sv
// ---------------------------------------------------------------------------
// tb_timer_gpio_nch
//   Self-checking bench for timer_gpio_nch. Main instance: NCH=4, PRESC=1.
//   A second instance (NCH=2, PRESC=3) exercises the prescaler.
//   Register reads are scoreboarded: the expected value is queued when the
//   read is issued and compared when rdata appears.
// ---------------------------------------------------------------------------
module tb_timer_gpio_nch;

    localparam int AW  = 5;
    localparam int AW2 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pin1;
    logic [1:0] pin2;
    logic       irq1, irq2;
    logic [3:0] pin_in1;
    logic [1:0] pin_in2;

    timer_gpio_nch_if #(.AW(AW),  .CW(16)) bus  ();
    timer_gpio_nch_if #(.AW(AW2), .CW(16)) bus2 ();

    timer_gpio_nch #(.NCH(4), .CW(16), .PRESC(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
`ifdef TIMER_GPIO_CAPTURE_EN
        .pin_in (pin_in1),
`endif
        .pin    (pin1),
        .irq    (irq1)
    );

    timer_gpio_nch #(.NCH(2), .CW(16), .PRESC(3)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus2),
`ifdef TIMER_GPIO_CAPTURE_EN
        .pin_in (pin_in2),
`endif
        .pin    (pin2),
        .irq    (irq2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    bit   rd_q1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read monitor: rdata is valid on the negedge after the rd_en edge.
    always @(posedge clk) rd_q1 <= bus.rd_en;

    always @(negedge clk) begin
        if (rd_q1) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.tag, bus.rdata, e.val);
            end
        end
    end

    // All bus tasks are entered on a negedge and return on the next negedge.
    task automatic wr(input int ch, input int r, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = AW'(ch * 8 + r);
        bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input logic [15:0] e, input string tag);
        exp_t x;
        bus.rd_en = 1'b1;
        bus.addr  = AW'(ch * 8 + r);
        x.tag = tag;
        x.val = e;
        sb_q.push_back(x);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic wr2(input int ch, input int r, input logic [15:0] d);
        bus2.wr_en = 1'b1;
        bus2.addr  = AW2'(ch * 8 + r);
        bus2.wdata = d;
        @(negedge clk);
        bus2.wr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mc;
        logic        mp;
        logic [15:0] c1, c2;

        reset      = 1'b1;
        bus.wr_en  = 1'b0; bus.rd_en  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
        bus2.wr_en = 1'b0; bus2.rd_en = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        pin_in1    = '0;
        pin_in2    = '0;

        repeat (3) @(negedge clk);
        check("rst_pin",   pin1,      4'h0);
        check("rst_irq",   irq1,      1'b0);
        check("rst_rdata", bus.rdata, 16'h0);
        reset = 1'b0;
        rd(0, 0, 16'h0, "rst_ctrl");
        rd(2, 1, 16'h0, "rst_period");

        // ---- 1: PWM, PERIOD=4, COMPARE=2 -> 1,1,0,0,0 repeating ----
        wr(0, 1, 16'd4);
        wr(0, 2, 16'd2);
        wr(0, 0, 16'h7);
        mc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t1_pwm[%0d]", i), pin1[0], (mc < 2) ? 1'b1 : 1'b0);
            mc = (mc >= 4) ? 0 : mc + 1;
        end
        rd(0, 4, 16'h1, "t1_status_wrap");
        check("t1_irq", irq1, 1'b0);
        rd(0, 0, 16'h7, "t1_ctrl");
        rd(0, 1, 16'd4, "t1_period");
        rd(0, 6, 16'h0, "t1_reg6");
        wr(0, 0, 16'h0);

        // ---- 2: one-shot, PERIOD=3, irq_en ----
        wr(1, 1, 16'd3);
        wr(1, 0, 16'hD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t2_oneshot[%0d]", i), pin1[1], (i < 3) ? 1'b1 : 1'b0);
        end
        check("t2_irq_set", irq1, 1'b1);
        rd(1, 0, 16'h9, "t2_ctrl_autoclear");
        rd(1, 4, 16'h1, "t2_status");
        wr(1, 4, 16'h1);
        check("t2_irq_clr", irq1, 1'b0);
        rd(1, 4, 16'h0, "t2_status_clr");

        // ---- 3: toggle, PERIOD=2, then PERIOD=0 freezes ----
        wr(2, 1, 16'd2);
        wr(2, 0, 16'h6);
        mc = 0;
        mp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (mc >= 2) begin
                mc = 0;
                mp = ~mp;
            end else begin
                mc = mc + 1;
            end
            @(negedge clk);
            check($sformatf("t3_toggle[%0d]", i), pin1[2], mp);
        end
        wr(2, 1, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3_frozen_pin[%0d]", i), pin1[2], 1'b0);
        end
        rd(2, 3, 16'h0, "t3_count_frozen");
        wr(2, 0, 16'h0);

        // ---- 4: PWM extremes and set-vs-clear collision ----
        wr(0, 1, 16'd8);
        wr(0, 2, 16'd0);
        wr(0, 0, 16'h7);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t4_cmp0[%0d]", i), pin1[0], 1'b0);
        end
        wr(0, 2, 16'd9);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t4_cmp9[%0d]", i), pin1[0], 1'b1);
        end
        wr(0, 0, 16'h7);             // restart: count 0
        wr(0, 4, 16'h1);             // count 1, clear old wrap
        rd(0, 4, 16'h0, "t4_status_clr");
        repeat (6) @(negedge clk);   // count 8
        wr(0, 4, 16'h1);             // wrap on this edge, clear collides
        rd(0, 4, 16'h1, "t4_set_wins");

        // ---- 5: reset mid-count ----
        wr(0, 0, 16'hF);
        repeat (3) @(negedge clk);
        rd(0, 3, 16'd3, "t5_count_pre");
        check("t5_pin_pre", pin1[0], 1'b1);
        check("t5_irq_pre", irq1, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t5_pin_rst",   pin1,      4'h0);
        check("t5_irq_rst",   irq1,      1'b0);
        check("t5_rdata_rst", bus.rdata, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_pin_hold[%0d]", i), pin1, 4'h0);
        end
        reset = 1'b0;
        rd(0, 3, 16'h0, "t5_count_post");
        rd(0, 0, 16'h0, "t5_ctrl_post");
        rd(0, 4, 16'h0, "t5_status_post");

        // ---- 6: capture ----
        wr(3, 1, 16'd100);
        wr(3, 0, 16'h5);
        repeat (40) @(negedge clk);  // count 40
`ifdef TIMER_GPIO_CAPTURE_EN
        pin_in1[3] = 1'b1;
        repeat (5) @(negedge clk);
        pin_in1[3] = 1'b0;
        rd(3, 5, 16'd42, "t6_capture");
        rd(3, 4, 16'h2,  "t6_status_cap");
`else
        rd(3, 5, 16'h0, "t6_capture_absent");
        rd(3, 4, 16'h0, "t6_status_nocap");
`endif
        wr(3, 0, 16'h0);

        // ---- prescaler: PRESC=3 -> 10 counts in 30 cycles ----
        wr2(1, 1, 16'd1000);
        wr2(1, 0, 16'h5);
        bus2.rd_en = 1'b1;
        bus2.addr  = AW2'(8 + 3);
        @(negedge clk);
        bus2.rd_en = 1'b0;
        c1 = bus2.rdata;
        repeat (29) @(negedge clk);
        bus2.rd_en = 1'b1;
        @(negedge clk);
        bus2.rd_en = 1'b0;
        c2 = bus2.rdata;
        check("presc_step", 16'(c2 - c1), 16'd10);
        check("presc_pin",  pin2[1], 1'b1);

        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
